// File: rtl/aes_dec_top_if.sv
// aes_dec_top_if
//  Bundles the start request, block inputs and result outputs of the AES-128
//  inverse cipher. The clock and reset stay as plain ports on the module.
//  Signals:
//   AES_en             start request, level-sampled while the core is idle
//   AES_data_in        128-bit ciphertext, [127:120] = state byte 0
//   AES_key_in         128-bit cipher key (round key 0), same byte order
//   AES_busy           high from the capture edge until the result edge
//   AES_data_out       128-bit plaintext
//   AES_data_out_valid one-cycle pulse marking a fresh AES_data_out
//  Modports: master drives the request side, slave is the decryption core.
interface aes_dec_top_if;
    logic         AES_en;
    logic [127:0] AES_data_in;
    logic [127:0] AES_key_in;
    logic         AES_busy;
    logic [127:0] AES_data_out;
    logic         AES_data_out_valid;

    modport master (
        output AES_en,
        output AES_data_in,
        output AES_key_in,
        input  AES_busy,
        input  AES_data_out,
        input  AES_data_out_valid
    );

    modport slave (
        input  AES_en,
        input  AES_data_in,
        input  AES_key_in,
        output AES_busy,
        output AES_data_out,
        output AES_data_out_valid
    );
endinterface

// File: rtl/aes_dec_top.sv
// aes_dec_top
//  Iterative AES-128 inverse cipher, one round per clock. The caller supplies
//  the ciphertext and the ordinary cipher key; the core first runs the forward
//  key schedule to reach the last round key, then walks the schedule backwards
//  while it peels off one inverse round per edge.
//  Sequence after a capture edge E0: E1..E10 forward key expansion, E11 initial
//  AddRoundKey with K10, E12..E21 inverse rounds (final one without
//  InvMixColumns). The plaintext and a one-cycle valid appear after E21.
//  Parameters:
//   NR              number of rounds, must be 10
//   CLEAR_ON_START  1: zero AES_data_out on capture, 0: hold the last result
//  Ports:
//   AES_clk  clock, rising edge
//   AES_rst  asynchronous active-high reset
//   bus      aes_dec_top_if.slave (request, block inputs, result outputs)
module aes_dec_top #(
    parameter int NR             = 10,
    parameter bit CLEAR_ON_START = 1'b0
) (
    input  logic         AES_clk,
    input  logic         AES_rst,
    aes_dec_top_if.slave bus
);

    generate
        if (NR != 10) begin : g_nr_check
            $error("aes_dec_top: NR must be 10 (AES-128 only)");
        end
    endgenerate

    // ------------------------------------------------------------------
    // GF(2^8) helpers (polynomial 0x11b)
    // ------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse; it also maps 0 to 0 for free.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = x;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] y);
        logic [7:0] a;
        a = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
        return gf_inv(a);
    endfunction

    function automatic logic [7:0] rcon_of(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // One InvMixColumns column; coefficients 0e 0b 0d 09 built from xtime.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_INIT, ST_ROUND} fsm_t;

    fsm_t         fsm_reg;
    logic [127:0] state_reg;
    logic [127:0] key_reg;
    logic [3:0]   cnt_reg;
    logic         busy_reg;
    logic [127:0] data_out_reg;
    logic         valid_reg;

    // ------------------------------------------------------------------
    // Key path. The forward and backward schedule steps share one SubWord:
    // forward takes the current w3, backward takes the recovered w3, and both
    // then XOR the same term into w0.
    // ------------------------------------------------------------------
    logic [31:0]  kw0, kw1, kw2, kw3;
    logic [31:0]  pw1, pw2, pw3;
    logic [31:0]  nw0, nw1, nw2, nw3;
    logic [31:0]  rot_in, rot_word, sub_word, key_t;
    logic [7:0]   rcon_sel;
    logic [127:0] next_key, prev_key;

    assign kw0 = key_reg[127:96];
    assign kw1 = key_reg[95:64];
    assign kw2 = key_reg[63:32];
    assign kw3 = key_reg[31:0];

    assign pw3 = kw3 ^ kw2;
    assign pw2 = kw2 ^ kw1;
    assign pw1 = kw1 ^ kw0;

    assign rot_in   = (fsm_reg == ST_EXPAND) ? kw3 : pw3;
    assign rot_word = {rot_in[23:0], rot_in[31:24]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_key_sbox
            assign sub_word[31-8*gi -: 8] = sbox_fwd(rot_word[31-8*gi -: 8]);
        end
    endgenerate

    // Going backwards from K(r) uses rcon of round r, and cnt holds r-1.
    assign rcon_sel = rcon_of((fsm_reg == ST_EXPAND) ? cnt_reg : cnt_reg + 4'd1);
    assign key_t    = sub_word ^ {rcon_sel, 24'h000000};

    assign nw0 = kw0 ^ key_t;
    assign nw1 = kw1 ^ nw0;
    assign nw2 = kw2 ^ nw1;
    assign nw3 = kw3 ^ nw2;

    assign next_key = {nw0, nw1, nw2, nw3};
    assign prev_key = {kw0 ^ key_t, pw1, pw2, pw3};

    // ------------------------------------------------------------------
    // Data path: InvShiftRows folds into the S-box input wiring.
    // Byte k sits in column k/4, row k%4; row r is rotated right by r.
    // ------------------------------------------------------------------
    logic [127:0] isb;
    logic [127:0] ark;
    logic [127:0] imc;

    generate
        for (gi = 0; gi < 16; gi++) begin : g_inv_sbox
            localparam int SRC = (((gi / 4) + 4 - (gi % 4)) % 4) * 4 + (gi % 4);
            assign isb[127-8*gi -: 8] = sbox_inv(state_reg[127-8*SRC -: 8]);
        end
    endgenerate

    assign ark = isb ^ prev_key;

    generate
        for (gi = 0; gi < 4; gi++) begin : g_inv_mix
            assign imc[127-32*gi -: 32] = inv_mix_col(ark[127-32*gi -: 32]);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    always_ff @(posedge AES_clk or posedge AES_rst) begin
        if (AES_rst) begin
            fsm_reg      <= ST_IDLE;
            state_reg    <= '0;
            key_reg      <= '0;
            cnt_reg      <= '0;
            busy_reg     <= 1'b0;
            data_out_reg <= '0;
            valid_reg    <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            case (fsm_reg)
                ST_IDLE: begin
                    if (bus.AES_en) begin
                        state_reg <= bus.AES_data_in;
                        key_reg   <= bus.AES_key_in;
                        cnt_reg   <= 4'd1;
                        busy_reg  <= 1'b1;
                        fsm_reg   <= ST_EXPAND;
                        if (CLEAR_ON_START) data_out_reg <= '0;
                    end
                end
                ST_EXPAND: begin
                    key_reg <= next_key;
                    if (cnt_reg == 4'd10) begin
                        fsm_reg <= ST_INIT;
                    end else begin
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end
                ST_INIT: begin
                    state_reg <= state_reg ^ key_reg;
                    cnt_reg   <= 4'd9;
                    fsm_reg   <= ST_ROUND;
                end
                ST_ROUND: begin
                    key_reg <= prev_key;
                    if (cnt_reg == 4'd0) begin
                        data_out_reg <= ark;
                        valid_reg    <= 1'b1;
                        busy_reg     <= 1'b0;
                        fsm_reg      <= ST_IDLE;
                    end else begin
                        state_reg <= imc;
                        cnt_reg   <= cnt_reg - 4'd1;
                    end
                end
                default: fsm_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.AES_busy           = busy_reg;
    assign bus.AES_data_out       = data_out_reg;
    assign bus.AES_data_out_valid = valid_reg;

endmodule
